// File: rtl/niios_qsys_nios2_div_pkg.sv
// Shared constants and state encoding for the Nios II sequential divider cell.
package niios_qsys_nios2_div_pkg;

   // One restoring iteration per quotient bit.
   localparam int DIV_ITERS = 32;

   // Cycles from the start-sampling cycle to the done pulse.
   localparam int DIV_LATENCY = 35;

   // Quotient reported when the divisor is zero, in either signedness.
   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

   // Controller states; explicit encodings keep the register layout stable.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_ITER = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } divState_e;

endpackage

// File: rtl/niios_qsys_nios2_div_step.sv
// One radix-2 restoring division step: shift the remainder left, pull in the
// next dividend bit, and keep the trial difference only if it is non-negative.
module niios_qsys_nios2_div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   rem_i,
   input  logic         quo_msb_i,
   input  logic [W-1:0] divisor_i,
   output logic [W:0]   rem_o,
   output logic         qbit_o
);

   logic [W+1:0] shifted;
   logic [W+1:0] diff;

   // The shifted value carries one spare top bit so the subtraction's sign is exact.
   always_comb begin
      shifted = {rem_i, quo_msb_i};
      diff    = shifted - {2'b00, divisor_i};
      if (diff[W+1]) begin
         rem_o  = shifted[W:0];
         qbit_o = 1'b0;
      end else begin
         rem_o  = diff[W:0];
         qbit_o = 1'b1;
      end
   end

endmodule

// File: rtl/niios_qsys_nios2_div_cell.sv
// Sequential 32-bit divider for the A-stage custom ALU path (div / divu).
// Operands are latched on start, reduced to magnitudes, divided with 32
// restoring steps, and the sign is re-applied before the done pulse.
module niios_qsys_nios2_div_cell
   import niios_qsys_nios2_div_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              A_div_start,
   input  logic              A_div_signed,
   input  logic [DATA_W-1:0] A_div_src1,
   input  logic [DATA_W-1:0] A_div_src2,
   input  logic              A_div_cancel,
   output logic              A_div_busy,
   output logic              A_div_done,
   output logic [DATA_W-1:0] A_div_cell_result
);

   localparam int CNT_W = $clog2(DIV_ITERS);

   divState_e         state_q,    state_d;
   logic              isSigned_q, isSigned_d;
   logic              neg_q,      neg_d;
   logic [DATA_W-1:0] dividend_q, dividend_d;
   logic [DATA_W-1:0] divisor_q,  divisor_d;
   logic [DATA_W:0]   rem_q,      rem_d;
   logic [DATA_W-1:0] quo_q,      quo_d;
   logic [CNT_W-1:0]  count_q,    count_d;
   logic [DATA_W-1:0] result_q,   result_d;

   logic [DATA_W-1:0] dividendMag;
   logic [DATA_W-1:0] divisorMag;
   logic [DATA_W:0]   stepRem;
   logic              stepBit;

   // Magnitudes of the latched operands; the most negative value maps onto itself,
   // which is exactly what makes the signed overflow case wrap naturally.
   always_comb begin
      dividendMag = (isSigned_q && dividend_q[DATA_W-1]) ? -dividend_q : dividend_q;
      divisorMag  = (isSigned_q && divisor_q[DATA_W-1])  ? -divisor_q  : divisor_q;
   end

   niios_qsys_nios2_div_step #(
      .W(DATA_W)
   ) u_step (
      .rem_i     (rem_q),
      .quo_msb_i (quo_q[DATA_W-1]),
      .divisor_i (divisor_q),
      .rem_o     (stepRem),
      .qbit_o    (stepBit)
   );

   // Controller and datapath next-state; cancel overrides everything and freezes the result.
   always_comb begin
      state_d    = state_q;
      isSigned_d = isSigned_q;
      neg_d      = neg_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      count_d    = count_q;
      result_d   = result_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (A_div_start) begin
               state_d    = ST_PREP;
               isSigned_d = A_div_signed;
               dividend_d = A_div_src1;
               divisor_d  = A_div_src2;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PREP: begin
            neg_d = isSigned_q & (dividend_q[DATA_W-1] ^ divisor_q[DATA_W-1]);
            if (divisorMag == '0) begin
               result_d = DIV_BY_ZERO_Q;
               state_d  = ST_DONE;
            end else begin
               rem_d     = '0;
               quo_d     = dividendMag;
               divisor_d = divisorMag;
               count_d   = CNT_W'(DIV_ITERS - 1);
               state_d   = ST_ITER;
            end
         end
         ST_ITER: begin
            rem_d = stepRem;
            quo_d = {quo_q[DATA_W-2:0], stepBit};
            if (count_q == '0) begin
               state_d = ST_FIX;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         ST_FIX: begin
            result_d = neg_q ? -quo_q : quo_q;
            state_d  = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (A_div_cancel) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   // State registers with asynchronous active-low reset back to an idle, zeroed cell.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         isSigned_q <= 1'b0;
         neg_q      <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         count_q    <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         isSigned_q <= isSigned_d;
         neg_q      <= neg_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         count_q    <= count_d;
         result_q   <= result_d;
      end
   end

   // Outputs decode straight from registered state so inputs never reach them combinationally.
   always_comb begin
      A_div_busy        = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
      A_div_done        = (state_q == ST_DONE);
      A_div_cell_result = result_q;
   end

endmodule

// File: tb/tb_niios_qsys_nios2_div_cell.sv
// Bench for the sequential divider cell: a table of directed divisions plus
// hand-written sequences for ignored start, cancel, back-to-back and reset.
module tb_niios_qsys_nios2_div_cell;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        sgn;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] q;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   niios_qsys_nios2_div_cell #(
      .DATA_W(32)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .A_div_start       (start),
      .A_div_signed      (sgn),
      .A_div_src1        (src1),
      .A_div_src2        (src2),
      .A_div_cancel      (cancel),
      .A_div_busy        (busy),
      .A_div_done        (done),
      .A_div_cell_result (result)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a falling edge: the following rising edge samples the start (cycle N).
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
      src1  = a;
      src2  = b;
      sgn   = s;
      start = 1'b1;
   endtask

   // Walks falling edges N+1, N+2, ... until done; lat is 0 if the budget expires.
   task automatic waitDone(output int lat, output logic [31:0] res, output int busyErr);
      lat     = 0;
      res     = '0;
      busyErr = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (done) begin
            lat = i;
            res = result;
            if (busy) busyErr++;
            break;
         end
         if (!busy) busyErr++;
      end
   endtask

   initial begin
      int          lat;
      int          busyErr;
      int          doneCount;
      logic [31:0] res;

      reset_n = 1'b0;
      start   = 1'b0;
      sgn     = 1'b0;
      src1    = '0;
      src2    = '0;
      cancel  = 1'b0;

      vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        35};
      vecs[1]  = '{32'hFFFFFF9C,  32'd7,         1'b1, 32'hFFFFFFF2,  35};
      vecs[2]  = '{32'd100,       32'hFFFFFFF9,  1'b1, 32'hFFFFFFF2,  35};
      vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  35};
      vecs[4]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  35};
      vecs[5]  = '{32'd5,         32'd9,         1'b0, 32'd0,         35};
      vecs[6]  = '{32'd1234,      32'd0,         1'b0, 32'hFFFFFFFF,  2};
      vecs[7]  = '{32'd1234,      32'd0,         1'b1, 32'hFFFFFFFF,  2};
      vecs[8]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32'd14,        35};
      vecs[9]  = '{32'hFFFFFF9C,  32'd7,         1'b0, 32'h24924916,  35};
      vecs[10] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  35};
      vecs[11] = '{32'h80000000,  32'd2,         1'b0, 32'h40000000,  35};

      #1;
      checkOutput("reset_busy",   {31'd0, busy}, 32'd0);
      checkOutput("reset_done",   {31'd0, done}, 32'd0);
      checkOutput("reset_result", result,        32'd0);

      @(negedge clk);
      reset_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s);
         waitDone(lat, res, busyErr);
         checkOutput($sformatf("v%0d_result", i),  res,        vecs[i].q);
         checkOutput($sformatf("v%0d_latency", i), 32'(lat),   32'(vecs[i].lat));
         checkOutput($sformatf("v%0d_busy", i),    32'(busyErr), 32'd0);
      end

      // Start raised at N+5 while busy must be ignored.
      @(negedge clk);
      applyStimulus(32'd100, 32'd7, 1'b0);
      lat = 0;
      res = '0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == 5) applyStimulus(32'd200, 32'd3, 1'b1);
         if (i == 6) start = 1'b0;
         if (done) begin
            lat = i;
            res = result;
            break;
         end
      end
      checkOutput("ignstart_latency", 32'(lat), 32'd35);
      checkOutput("ignstart_result",  res,      32'd14);

      // Cancel at N+10: busy drops at N+11, no done, result keeps 14.
      @(negedge clk);
      applyStimulus(32'd1000, 32'd10, 1'b0);
      doneCount = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (done) doneCount++;
         if (i == 10) cancel = 1'b1;
         if (i == 11) begin
            checkOutput("cancel_busy", {31'd0, busy}, 32'd0);
            cancel = 1'b0;
         end
      end
      checkOutput("cancel_nodone", 32'(doneCount), 32'd0);
      checkOutput("cancel_result", result,         32'd14);

      // Back-to-back: second start issued in the first DONE cycle.
      @(negedge clk);
      applyStimulus(32'd100, 32'd7, 1'b0);
      waitDone(lat, res, busyErr);
      checkOutput("b2b_first_latency", 32'(lat), 32'd35);
      checkOutput("b2b_first_result",  res,      32'd14);
      applyStimulus(32'hFFFFFF9C, 32'd7, 1'b1);
      waitDone(lat, res, busyErr);
      checkOutput("b2b_second_latency", 32'(lat),     32'd35);
      checkOutput("b2b_second_result",  res,          32'hFFFFFFF2);
      checkOutput("b2b_second_busy",    32'(busyErr), 32'd0);
      @(negedge clk);
      checkOutput("b2b_done_pulse", {31'd0, done}, 32'd0);

      // Reset asserted at N+20 clears outputs at once and no done follows.
      @(negedge clk);
      applyStimulus(32'd100, 32'd7, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_busy",   {31'd0, busy}, 32'd0);
      checkOutput("midreset_done",   {31'd0, done}, 32'd0);
      checkOutput("midreset_result", result,        32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      doneCount = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("midreset_nodone", 32'(doneCount), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/niios_qsys_nios2_div_cell.md
# niios_qsys_nios2_div_cell

Sequential 32-bit integer divider cell for the Nios II custom ALU path. It performs the inverse of the multiply cell and implements `div` and `divu`. It uses a radix-2 restoring algorithm over 32 iteration cycles with a start/done handshake, and it sits beside the multiply cell in the A-stage. The pipeline stalls on `A_div_busy` and captures `A_div_cell_result` on `A_div_done`.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `A_div_start`  in  1  request a new division; sampled only when not busy.
- `A_div_signed`  in  1  1 selects `div` (two's complement), 0 selects `divu`; latched with start.
- `A_div_src1`  in  32  dividend; latched with start.
- `A_div_src2`  in  32  divisor; latched with start.
- `A_div_cancel`  in  1  pipeline flush; aborts any operation in progress.
- `A_div_busy`  out  1  high in PREP, ITER and FIX.
- `A_div_done`  out  1  one-cycle pulse; the result is valid from this cycle onward.
- `A_div_cell_result`  out  32  quotient; held until the next accepted start.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE or DONE with `A_div_start`=1:
  - latch operands and the signed flag;
  - go to PREP.
- PREP:
  - signed mode: take the magnitudes of both operands and record `neg_q = src1[31]^src2[31]`; unsigned mode: `neg_q = 0`.
  - Divisor == 0: load result 0xFFFFFFFF, go to DONE (skip ITER/FIX).
  - Otherwise: clear the 33-bit partial remainder, load the dividend magnitude into the quotient shift register, set count=31, go to ITER.
- ITER, once per cycle:
  - shift {rem, quo} left by 1;
  - trial subtract the divisor magnitude from the rem;
  - if the difference is non-negative, keep it and set quo[0]=1, else restore;
  - after count==0, go to FIX.
- FIX:
  - result = `neg_q` ? −quo : quo, truncated to 32 bits;
  - go to DONE.
- DONE:
  - `A_div_done`=1 for this cycle only;
  - next state IDLE, or PREP if `A_div_start`=1.
- Rounding truncates toward zero.
- Signed overflow 0x80000000 / 0xFFFFFFFF yields 0x80000000, by natural wrap with no special case.
- `A_div_start` while busy is ignored. No queueing.
- `A_div_cancel`:
  - in any state, the next state is IDLE, done is suppressed and the result is unchanged;
  - it wins over a simultaneous start.

## Timing
- Reset values: state IDLE, `A_div_busy`=0, `A_div_done`=0, `A_div_cell_result`=0, internal registers 0.
- Start sampled in cycle N gives:
  - PREP in N+1;
  - ITER in N+2..N+33;
  - FIX in N+34;
  - DONE with `A_div_done`=1 in N+35.
- Fixed latency is 35 cycles.
- Divide-by-zero: `A_div_done` in N+2.
- Back-to-back: a start in the DONE cycle gives the next DONE 35 cycles later, so throughput is one divide per 35 cycles.
- `A_div_busy` is high N+1..N+34 and low in IDLE and DONE.
- Outputs are driven from registers; there is no combinational path from inputs to outputs.
- Reset asserted mid-operation: immediate return to the reset values, no done.

## Structure
- Package `niios_qsys_nios2_div_pkg`:
  - state enum;
  - `DIV_ITERS`=32;
  - `DIV_LATENCY`=35;
  - `DIV_BY_ZERO_Q`=32'hFFFFFFFF.
- Sub-module `niios_qsys_nios2_div_step`: combinational single restoring step.
  - In: rem[32:0], quo_msb, divisor[31:0].
  - Out: next rem, quotient bit.
- Top module holds the FSM, counter, operand/sign registers and the result register.

## Test plan
- Unsigned: src1=100, src2=7, signed=0 -> done at N+35, result=14; busy high N+1..N+34.
- Signed:
  - src1=-100 (0xFFFFFF9C), src2=7 -> result=0xFFFFFFF2 (−14);
  - src1=100, src2=-7 -> 0xFFFFFFF2.
- Edges:
  - 0x80000000 / 0xFFFFFFFF signed -> 0x80000000;
  - 0xFFFFFFFF / 1 unsigned -> 0xFFFFFFFF;
  - 5 / 9 -> 0.
- Divide-by-zero: 1234 / 0 in either mode -> done at N+2, result 0xFFFFFFFF.
- Cancel and ignored start:
  - cancel at N+10 -> busy low at N+11, no done, result unchanged;
  - a start asserted at N+5 during another operation is ignored.
- Back-to-back and reset:
  - a start in the DONE cycle gives a second done 35 cycles later with the correct value;
  - reset_n low at N+20 -> all outputs 0 immediately, no done afterwards.
